dm_stage: RTL and testbench

Memory stage of the 16-bit pipeline. It consumes the EX/DM latch outputs and runs a req/ack handshake to a variable-latency data memory, holding the upstream stages with DM_Stall while an access is in flight. It produces a registered DM/WB bundle for writeback and handles halt, misaligned access and memory-timeout termination.

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dm_wait_counter.sv | 29 ++
 rtl/dm_stage.sv | 171 +++++++++++++++++
 tb/tb_dm_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the memory (DM) pipeline stage: FSM state codes,
// halt polarity, DM/WB bundle field widths and the access fault check.
package dm_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WAIT   = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    // HaltSig is active-low: 0 marks a HALT instruction
    localparam logic HALT_N_ACTIVE = 1'b0;
    localparam logic HALT_N_IDLE   = 1'b1;

    // DM/WB bundle field widths
    localparam int unsigned DMWB_DATA_W = 16;
    localparam int unsigned DMWB_REG_W  = 3;

    // A memory op is faulty when it is both load and store, or when it
    // targets an odd (non word-aligned) address.
    function automatic logic is_mem_fault(input logic rd, input logic wr,
                                          input logic addr_lsb);
        return (rd & wr) | ((rd | wr) & addr_lsb);
    endfunction

endpackage

// File: rtl/dm_wait_counter.sv
// Counts WAIT cycles spent without a memory acknowledge and flags the
// cycle on which the TIMEOUT-th such cycle is being spent.
module dm_wait_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count cycles waited; saturate at the terminal value
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/dm_stage.sv
// Memory stage of the 16-bit pipeline: req/ack handshake to a
// variable-latency data memory, upstream stall, registered DM/WB bundle,
// plus halt, misaligned/illegal access and timeout termination.
module dm_stage
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EXDM_Valid,
    input  logic [DATA_W-1:0]     EXDM_ALUOut,
    input  logic [DATA_W-1:0]     EXDM_RTData,
    input  logic [DATA_W-1:0]     EXDM_PC,
    input  logic                  EXDM_MemWrt,
    input  logic                  EXDM_MemRead,
    input  logic                  EXDM_HaltSig,
    input  logic                  EXDM_RegWrt,
    input  logic [DMWB_REG_W-1:0] EXDM_WrReg,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  DM_Stall,
    output logic                  DM_Err,
    output logic                  DMWB_Valid,
    output logic [DATA_W-1:0]     DMWB_MemData,
    output logic [DATA_W-1:0]     DMWB_ALUOut,
    output logic [DATA_W-1:0]     DMWB_PC,
    output logic                  DMWB_RegWrt,
    output logic [DMWB_REG_W-1:0] DMWB_WrReg,
    output logic                  DMWB_HaltSig
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       in_idle;
    logic       in_wait;
    logic       access;
    logic       fault;
    logic       start;
    logic       ack_ok;
    logic       tc;
    logic       timeout;
    logic       halt_req;
    logic       stall_raw;
    logic       dmwb_we;
    logic       valid_next;

    assign in_idle  = (state == ST_IDLE);
    assign in_wait  = (state == ST_WAIT);
    assign access   = EXDM_Valid & (EXDM_MemRead | EXDM_MemWrt);
    assign fault    = EXDM_Valid & is_mem_fault(EXDM_MemRead, EXDM_MemWrt, EXDM_ALUOut[0]);
    assign start    = in_idle & access & ~fault;
    assign ack_ok   = in_wait & mem_ack;
    assign timeout  = in_wait & ~mem_ack & tc;
    assign halt_req = in_idle & EXDM_Valid & ~access & (EXDM_HaltSig == HALT_N_ACTIVE);

    // Acks arriving outside WAIT are dropped, so the DM/WB enable uses the
    // WAIT-qualified ack rather than the raw input.
    assign dmwb_we    = (in_idle & ~stall_raw) | ack_ok;
    assign valid_next = (in_idle & EXDM_Valid & ~access) | ack_ok;
    assign DM_Stall   = stall_raw & ~rst;

    dm_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (in_wait & ~mem_ack),
        .tc     (tc)
    );

    // Upstream stall: any memory op in IDLE, WAIT until ack, always in HALTED
    always_comb begin
        stall_raw = 1'b1;
        case (state)
            ST_IDLE: stall_raw = access;
            ST_WAIT: stall_raw = ~mem_ack;
            default: stall_raw = 1'b1;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fault) begin
                    state_next = ST_HALTED;
                end else if (start) begin
                    state_next = ST_WAIT;
                end else if (halt_req) begin
                    state_next = ST_HALTED;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end else if (tc) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory request interface: launch on a legal access, drop on ack or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_wr    <= EXDM_MemWrt;
            mem_addr  <= EXDM_ALUOut;
            mem_wdata <= EXDM_RTData;
        end else if (ack_ok || timeout) begin
            mem_req   <= 1'b0;
        end
    end

    // Sticky error flag for faulty accesses and memory timeouts
    always_ff @(posedge clk) begin
        if (rst) begin
            DM_Err <= 1'b0;
        end else if ((in_idle && fault) || timeout) begin
            DM_Err <= 1'b1;
        end
    end

    // DM/WB bundle; Valid and RegWrt update every cycle so bubbles never write back
    always_ff @(posedge clk) begin
        if (rst) begin
            DMWB_Valid   <= 1'b0;
            DMWB_RegWrt  <= 1'b0;
            DMWB_MemData <= '0;
            DMWB_ALUOut  <= '0;
            DMWB_PC      <= '0;
            DMWB_WrReg   <= '0;
            DMWB_HaltSig <= HALT_N_IDLE;
        end else begin
            DMWB_Valid  <= valid_next;
            DMWB_RegWrt <= valid_next & EXDM_RegWrt;
            if (dmwb_we) begin
                DMWB_MemData <= (ack_ok && !mem_wr) ? mem_rdata : '0;
                DMWB_ALUOut  <= EXDM_ALUOut;
                DMWB_PC      <= EXDM_PC;
                DMWB_WrReg   <= EXDM_WrReg;
                DMWB_HaltSig <= EXDM_Valid ? EXDM_HaltSig : HALT_N_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: transaction-level expectations for
// directed and randomized instructions driven through a responsive memory.
module tb_dm_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXDM_Valid;
    logic [15:0] EXDM_ALUOut;
    logic [15:0] EXDM_RTData;
    logic [15:0] EXDM_PC;
    logic        EXDM_MemWrt;
    logic        EXDM_MemRead;
    logic        EXDM_HaltSig;
    logic        EXDM_RegWrt;
    logic [2:0]  EXDM_WrReg;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        DM_Stall;
    logic        DM_Err;
    logic        DMWB_Valid;
    logic [15:0] DMWB_MemData;
    logic [15:0] DMWB_ALUOut;
    logic [15:0] DMWB_PC;
    logic        DMWB_RegWrt;
    logic [2:0]  DMWB_WrReg;
    logic        DMWB_HaltSig;

    int checks   = 0;
    int failures = 0;
    logic err_exp = 1'b0;
    logic halted  = 1'b0;

    always #5 clk = ~clk;

    dm_stage #(
        .DATA_W  (16),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .EXDM_Valid   (EXDM_Valid),
        .EXDM_ALUOut  (EXDM_ALUOut),
        .EXDM_RTData  (EXDM_RTData),
        .EXDM_PC      (EXDM_PC),
        .EXDM_MemWrt  (EXDM_MemWrt),
        .EXDM_MemRead (EXDM_MemRead),
        .EXDM_HaltSig (EXDM_HaltSig),
        .EXDM_RegWrt  (EXDM_RegWrt),
        .EXDM_WrReg   (EXDM_WrReg),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .DM_Stall     (DM_Stall),
        .DM_Err       (DM_Err),
        .DMWB_Valid   (DMWB_Valid),
        .DMWB_MemData (DMWB_MemData),
        .DMWB_ALUOut  (DMWB_ALUOut),
        .DMWB_PC      (DMWB_PC),
        .DMWB_RegWrt  (DMWB_RegWrt),
        .DMWB_WrReg   (DMWB_WrReg),
        .DMWB_HaltSig (DMWB_HaltSig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        EXDM_Valid   = 1'b0;
        EXDM_ALUOut  = '0;
        EXDM_RTData  = '0;
        EXDM_PC      = '0;
        EXDM_MemWrt  = 1'b0;
        EXDM_MemRead = 1'b0;
        EXDM_HaltSig = 1'b1;
        EXDM_RegWrt  = 1'b0;
        EXDM_WrReg   = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    // Assert reset for one edge (EXDM inputs left as the caller set them),
    // check every output, then release with an empty EX/DM latch.
    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req",     mem_req, 0);
        chk("rst_wr",      mem_wr, 0);
        chk("rst_addr",    mem_addr, 0);
        chk("rst_wdata",   mem_wdata, 0);
        chk("rst_stall",   DM_Stall, 0);
        chk("rst_err",     DM_Err, 0);
        chk("rst_valid",   DMWB_Valid, 0);
        chk("rst_memdata", DMWB_MemData, 0);
        chk("rst_aluout",  DMWB_ALUOut, 0);
        chk("rst_pc",      DMWB_PC, 0);
        chk("rst_regwrt",  DMWB_RegWrt, 0);
        chk("rst_wrreg",   DMWB_WrReg, 0);
        chk("rst_haltsig", DMWB_HaltSig, 1);
        clear_inputs();
        rst = 1'b0;
        err_exp = 1'b0;
        halted  = 1'b0;
    endtask

    // Present one instruction at a negedge and act as a memory that acks on
    // WAIT cycle delay+1. Returns at the negedge after the handoff edge, or
    // after a cycle budget if the stage never releases the stall.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] pc, input logic regwrt,
                             input logic [2:0] wrreg, input logic halt_n,
                             input int delay, input logic [15:0] rdata);
        logic acc, bad, tmo, done;
        int stall_cycles, req_cycles;
        acc = v & (rd | wr);
        bad = acc & (addr[0] | (rd & wr));
        tmo = acc & ~bad & (delay >= TO);
        EXDM_Valid = v;   EXDM_MemRead = rd; EXDM_MemWrt = wr;
        EXDM_ALUOut = addr; EXDM_RTData = wdata; EXDM_PC = pc;
        EXDM_RegWrt = regwrt; EXDM_WrReg = wrreg; EXDM_HaltSig = halt_n;
        stall_cycles = 0;
        req_cycles   = 0;
        done         = 1'b0;
        for (int c = 0; c < TO + 6 && !done; c++) begin
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (req_cycles == 1) chk("bubble_valid", DMWB_Valid, 0);
                mem_ack   = (req_cycles == delay + 1);
                mem_rdata = mem_ack ? rdata : 16'($urandom);
            end else begin
                // stray acks while no request is outstanding must be ignored
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end
            #1;
            if (DM_Stall === 1'b1) stall_cycles++;
            else done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        if (bad) begin
            err_exp = 1'b1;
            halted  = 1'b1;
            chk("fault_stuck",  done, 0);
            chk("fault_noreq",  req_cycles, 0);
            chk("fault_err",    DM_Err, 1);
            chk("fault_valid",  DMWB_Valid, 0);
            chk("fault_stall",  DM_Stall, 1);
        end else if (tmo) begin
            err_exp = 1'b1;
            halted  = 1'b1;
            chk("tmo_stuck",    done, 0);
            chk("tmo_reqcyc",   req_cycles, TO);
            chk("tmo_req",      mem_req, 0);
            chk("tmo_err",      DM_Err, 1);
            chk("tmo_valid",    DMWB_Valid, 0);
            chk("tmo_stall",    DM_Stall, 1);
        end else begin
            chk("handoff",      done, 1);
            chk("stall_cycles", stall_cycles, acc ? delay + 1 : 0);
            chk("req_cycles",   req_cycles, acc ? delay + 1 : 0);
            if (acc) begin
                chk("mem_addr",  mem_addr, addr);
                chk("mem_wr",    mem_wr, wr);
                chk("mem_wdata", mem_wdata, wdata);
                chk("req_drop",  mem_req, 0);
            end
            chk("dmwb_valid",  DMWB_Valid, v);
            chk("dmwb_regwrt", DMWB_RegWrt, v & regwrt);
            if (v) begin
                chk("dmwb_memdata", DMWB_MemData, (acc && rd) ? rdata : 16'h0000);
                chk("dmwb_aluout",  DMWB_ALUOut, addr);
                chk("dmwb_pc",      DMWB_PC, pc);
                chk("dmwb_wrreg",   DMWB_WrReg, wrreg);
                chk("dmwb_haltsig", DMWB_HaltSig, halt_n);
                if (!acc && !halt_n) halted = 1'b1;
            end else begin
                chk("bub_haltsig",  DMWB_HaltSig, 1);
            end
            chk("err_flag", DM_Err, err_exp);
        end
    endtask

    // After a HALT: random traffic must be ignored and the halt indication kept
    task automatic halted_hold();
        for (int c = 0; c < 3; c++) begin
            EXDM_Valid   = 1'b1;
            EXDM_MemRead = 1'($urandom);
            EXDM_MemWrt  = 1'b0;
            EXDM_ALUOut  = 16'($urandom) & 16'hFFFE;
            EXDM_RegWrt  = 1'b1;
            EXDM_HaltSig = 1'b1;
            mem_ack      = 1'($urandom);
            #1;
            chk("halt_stall", DM_Stall, 1);
            chk("halt_req",   mem_req, 0);
            @(posedge clk);
            @(negedge clk);
            chk("halt_valid",   DMWB_Valid, 0);
            chk("halt_regwrt",  DMWB_RegWrt, 0);
            chk("halt_haltsig", DMWB_HaltSig, 0);
        end
        mem_ack = 1'b0;
    endtask

    logic        r_v, r_rd, r_wr, r_rw, r_hn;
    logic [15:0] r_addr, r_wd, r_pc, r_rdata;
    logic [2:0]  r_reg;
    int          r_delay, r_kind;

    initial begin
        clear_inputs();
        @(negedge clk);
        do_reset();

        // ALU op passes straight through
        run_instr(1, 0, 0, 16'h1234, 16'h0000, 16'h0102, 1, 3'd3, 1, 0, 16'h0);
        // load, ack on 4th WAIT cycle
        run_instr(1, 1, 0, 16'h0040, 16'h1111, 16'h0104, 1, 3'd5, 1, 3, 16'hBEEF);
        // store, ack on first WAIT cycle
        run_instr(1, 0, 1, 16'h0010, 16'h5A5A, 16'h0106, 0, 3'd0, 1, 0, 16'hFFFF);
        // bubble with RegWrt set must not write back
        run_instr(0, 0, 0, 16'hAAAA, 16'h0, 16'h0108, 1, 3'd7, 0, 0, 16'h0);
        // ack lands on the TIMEOUT-th WAIT cycle: completes normally
        run_instr(1, 1, 0, 16'h0100, 16'h0, 16'h010A, 1, 3'd2, 1, TO - 1, 16'hC0DE);
        // misaligned load
        run_instr(1, 1, 0, 16'h0041, 16'h0, 16'h010C, 1, 3'd1, 1, 0, 16'h0);
        do_reset();
        // load read+write together is illegal
        run_instr(1, 1, 1, 16'h0020, 16'h0, 16'h010E, 1, 3'd1, 1, 0, 16'h0);
        do_reset();
        // memory never answers
        run_instr(1, 1, 0, 16'h0200, 16'h0, 16'h0110, 1, 3'd4, 1, 1000, 16'h0);
        do_reset();
        // halt instruction then ignored traffic
        run_instr(1, 0, 0, 16'h0300, 16'h0, 16'h0112, 0, 3'd0, 0, 0, 16'h0);
        halted_hold();
        do_reset();

        // reset in the middle of an outstanding load
        EXDM_Valid = 1'b1; EXDM_MemRead = 1'b1; EXDM_ALUOut = 16'h0400;
        EXDM_RTData = 16'h7777; EXDM_PC = 16'h0114; EXDM_RegWrt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midwait_req", mem_req, 1);
        do_reset();

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            r_kind  = $urandom_range(0, 19);
            r_v     = 1'b1; r_rd = 1'b0; r_wr = 1'b0; r_hn = 1'b1;
            r_addr  = 16'($urandom) & 16'hFFFE;
            r_wd    = 16'($urandom);
            r_pc    = 16'($urandom);
            r_rdata = 16'($urandom);
            r_reg   = 3'($urandom);
            r_rw    = 1'($urandom);
            r_delay = $urandom_range(0, TO - 1);
            if (r_kind == 0) begin
                r_v = 1'b0; r_rd = 1'($urandom); r_wr = 1'($urandom); r_hn = 1'($urandom);
            end else if (r_kind <= 11 && r_kind >= 6) begin
                r_rd = 1'b1;
            end else if (r_kind >= 12 && r_kind <= 16) begin
                r_wr = 1'b1;
            end else if (r_kind == 17) begin
                r_rd = r_rw; r_wr = ~r_rw; r_addr[0] = 1'b1;
            end else if (r_kind == 18) begin
                r_rd = 1'b1; r_delay = TO + 5;
            end else if (r_kind == 19) begin
                r_hn = 1'b0;
            end
            run_instr(r_v, r_rd, r_wr, r_addr, r_wd, r_pc, r_rw, r_reg, r_hn, r_delay, r_rdata);
            if (r_kind == 19) halted_hold();
            if (halted) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
